// File: rtl/switch_event_queue_if.sv
// Event stream between switch_event_queue (master) and its consumer (slave):
// valid/ready handshake plus head data and occupancy.
interface switch_event_queue_if #(
   parameter int unsigned DEPTH = 4
);
   logic                     evt_valid;
   logic                     evt_ready;
   logic [3:0]               evt_data;
   logic [$clog2(DEPTH):0]   evt_count;

   modport master (
      output evt_valid,
      output evt_data,
      output evt_count,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_data,
      input  evt_count,
      output evt_ready
   );
endinterface

// File: rtl/switch_event_queue.sv
// Converts debounced switch edges into queued {polarity, index} events, one per cycle.
// Falling-edge reporting and rise/fall cancellation are enabled by macro SWITCH_FALL_EVT_EN.
module switch_event_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            de_swt,
   switch_event_queue_if.master  evt
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic {
      S_INIT,
      S_RUN
   } state_t;

   state_t          r_state;
   logic [7:0]      r_prev;
   logic [7:0]      r_pend_rise;
   logic [7:0]      r_pend_fall;
   logic [3:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic [7:0]      w_edge;
   logic [7:0]      w_rise;
   logic [7:0]      w_fall;
   logic [7:0]      w_pend_any;
   logic            w_sel_vld;
   logic [2:0]      w_sel_idx;
   logic [7:0]      w_sel_mask;
   logic            w_full;
   logic            w_valid;
   logic            w_pop;
   logic            w_push;
   logic            w_push_pol;
   logic [7:0]      w_pr_base;
   logic [7:0]      w_pf_base;
   logic [7:0]      w_pr_nxt;
   logic [7:0]      w_pf_nxt;

   always_comb begin
      w_pend_any = r_pend_rise | r_pend_fall;
      w_sel_vld  = 1'b0;
      w_sel_idx  = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (w_pend_any[i] && !w_sel_vld) begin
            w_sel_vld = 1'b1;
            w_sel_idx = 3'(i);
         end
      end
   end

   assign w_edge     = (r_state == S_RUN) ? (de_swt ^ r_prev) : '0;
   assign w_rise     = w_edge & de_swt;
   assign w_fall     = w_edge & ~de_swt;
   assign w_valid    = (r_count != '0);
   assign w_full     = (r_count == CW'(DEPTH));
   assign w_pop      = w_valid && evt.evt_ready;
   assign w_push     = w_sel_vld && (!w_full || w_pop);
   assign w_sel_mask = w_push ? (8'b1 << w_sel_idx) : '0;

   // The pushed bit is retired first so an edge on that same index lands as a fresh pending bit.
   assign w_pr_base  = r_pend_rise & ~w_sel_mask;
   assign w_pf_base  = r_pend_fall & ~w_sel_mask;

`ifdef SWITCH_FALL_EVT_EN
   assign w_pr_nxt   = (w_pr_base & ~w_fall) | (w_rise & ~w_pf_base);
   assign w_pf_nxt   = (w_pf_base & ~w_rise) | (w_fall & ~w_pr_base);
   assign w_push_pol = r_pend_rise[w_sel_idx];
`else
   assign w_pr_nxt   = w_pr_base | w_rise;
   assign w_pf_nxt   = '0;
   assign w_push_pol = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_INIT;
         r_prev      <= '0;
         r_pend_rise <= '0;
         r_pend_fall <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         r_state     <= S_RUN;
         r_prev      <= de_swt;
         r_pend_rise <= w_pr_nxt;
         r_pend_fall <= w_pf_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is only exposed while the count says it is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_push_pol, w_sel_idx};
   end

   assign evt.evt_valid = w_valid;
   assign evt.evt_data  = w_valid ? r_mem[r_rd_ptr] : 4'b0000;
   assign evt.evt_count = r_count;

endmodule

// File: doc/switch_event_queue.md
SWITCH_EVENT_QUEUE -- requirements
Module: switch_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port de_swt  input  8  debounced switch levels from the switch debouncer, synchronous to clk.
REQ-005 SHALL have port evt_valid  output  1  FIFO head holds an event.
REQ-006 SHALL have port evt_ready  input  1  consumer accepts head event when evt_valid=1.
REQ-007 SHALL have port evt_data  output  4  head event: bit3 polarity (1=rise, 0=fall), bits2:0 switch index.
REQ-008 SHALL have port evt_count  output  clog2(DEPTH)+1  number of FIFO entries held.

Function
REQ-009 SHALL hold prev[7:0], the de_swt value sampled at the previous clock edge; edge vector = de_swt XOR prev.
REQ-010 SHALL, on the first clock edge after reset release, load prev from de_swt and generate no events (init cycle).
REQ-011 SHALL hold pend_rise[7:0] and pend_fall[7:0]; a detected rise on bit i sets pend_rise[i], a fall sets pend_fall[i].
REQ-012 SHALL cancel: an edge on bit i whose opposite-polarity pending bit is set clears that bit and sets nothing (net no change, no event).
REQ-013 SHALL, each cycle, push at most one event: the lowest index i with pend_rise[i] or pend_fall[i] set; the pushed pending bit clears on that edge.
REQ-014 SHALL push only if FIFO not full, or full with a pop on the same edge; otherwise pending bits hold, and no event is ever dropped.
REQ-015 SHALL let a pending bit set and another bit pushed on the same edge both take effect; a new edge on the index being pushed applies after the push.
REQ-016 SHALL give latency: input change sampled at edge k, pending set at k, pushed at k+1, evt_valid=1 after k+1 when FIFO was empty and bit i lowest.
REQ-017 SHALL pop when evt_valid && evt_ready; evt_ready ignored when evt_valid=0; evt_data stable while evt_valid && !evt_ready.
REQ-018 SHALL allow simultaneous push and pop at any occupancy (count unchanged when full or non-empty).
REQ-019 SHALL wrap read/write pointers modulo DEPTH; evt_count = DEPTH means full, 0 means empty.
REQ-020 SHALL drive evt_data = 0 when evt_valid = 0.

Reset
REQ-021 SHALL, on rst_n low, immediately clear prev, pend_rise, pend_fall, pointers, and the init flag; outputs evt_valid=0, evt_data=0, evt_count=0.
REQ-022 SHALL discard all queued and pending events on reset mid-operation; the init cycle repeats after release.

Configuration
REQ-023 SHALL use macro SWITCH_FALL_EVT_EN: when defined, falling edges are reported and REQ-012 cancellation applies.
REQ-024 SHALL, when SWITCH_FALL_EVT_EN is undefined, never set pend_fall, keep evt_data[3]=1 for every event, and leave a pending rise set through a later fall until pushed.

Verification
REQ-025 SHALL be verified by: reset with de_swt=8'h05, release -> no events; evt_count stays 0.
REQ-026 SHALL be verified by: de_swt 8'h00->8'h01, evt_ready=1 -> evt_valid pulse one cycle, evt_data=4'b1000, two edges after the change is sampled.
REQ-027 SHALL be verified by: de_swt 8'h00->8'h8A in one cycle, evt_ready=0 -> FIFO holds 4'b1001, 4'b1011, 4'b1111 in that order; evt_count=3.
REQ-028 SHALL be verified by: evt_ready=0, DEPTH=4, rises on bits 0..5 -> evt_count saturates at 4, bits 4 and 5 stay pending; evt_ready=1 then drains all 6 in index order, none lost.
REQ-029 SHALL be verified by: with FIFO full, bit 6 rise then fall before push -> with SWITCH_FALL_EVT_EN no bit-6 event; without it one 4'b1110 event.
REQ-030 SHALL be verified by: rst_n low with 3 queued events -> evt_valid=0, evt_count=0 asynchronously before next clk edge.
